// File: rtl/or_event_counter.sv
// Synchronises and debounces the OR-reduced input, pulsing and counting each accepted rising edge.
// Optional build macro OR_EVENT_CNT_SATURATE_EN: count saturates at max instead of wrapping.
//
// state      | meaning
// LOW        | debounced level low, waiting for s=1
// CONFIRM_HI | s went high, timing DEBOUNCE stable cycles before accepting
// HIGH       | debounced level high, waiting for s=0
// CONFIRM_LO | s went low, timing DEBOUNCE stable cycles before releasing
module or_event_counter #(
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 4,
   parameter int TMR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             or_in,
   input  logic             clr,
   output logic             event_pulse,
   output logic             level,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   typedef enum logic [1:0] {
      LOW        = 2'd0,
      CONFIRM_HI = 2'd1,
      HIGH       = 2'd2,
      CONFIRM_LO = 2'd3
   } state_t;

   localparam logic [TMR_W-1:0] TMR_TC  = TMR_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             s1;
   logic             s;
   state_t           state;
   state_t           state_nxt;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nxt;
   logic             accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s  <= 1'b0;
      end else begin
         s1 <= or_in;
         s  <= s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOW;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      accept    = 1'b0;
      case (state)
         LOW: begin
            if (s) begin
               state_nxt = CONFIRM_HI;
               timer_nxt = '0;
            end
         end
         CONFIRM_HI: begin
            if (!s) begin
               state_nxt = LOW;
            end else if (timer == TMR_TC) begin
               state_nxt = HIGH;
               accept    = 1'b1;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         HIGH: begin
            if (!s) begin
               state_nxt = CONFIRM_LO;
               timer_nxt = '0;
            end
         end
         CONFIRM_LO: begin
            if (s) begin
               state_nxt = HIGH;
            end else if (timer == TMR_TC) begin
               state_nxt = LOW;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: begin
            state_nxt = LOW;
            timer_nxt = '0;
         end
      endcase
   end

   // Outputs registered from next-state so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_pulse <= 1'b0;
         level       <= 1'b0;
      end else begin
         event_pulse <= accept;
         level       <= (state_nxt == HIGH) || (state_nxt == CONFIRM_LO);
      end
   end

   // clr takes priority over a coincident event; the pulse is unaffected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         if (count == CNT_MAX) begin
            overflow <= 1'b1;
`ifdef OR_EVENT_CNT_SATURATE_EN
            count    <= CNT_MAX;
`else
            count    <= '0;
`endif
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_or_event_counter.sv
// Directed bench for or_event_counter (DEBOUNCE=4, CNT_W=4): latency, glitch rejection,
// overflow, clr priority and mid-debounce reset.
module tb_or_event_counter;

   logic       clk;
   logic       rst;
   logic       or_in;
   logic       clr;
   logic       event_pulse;
   logic       level;
   logic [3:0] count;
   logic       overflow;

   int checks;
   int errors;
   int pulse_cnt;

   or_event_counter #(.DEBOUNCE(4), .CNT_W(4), .TMR_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .or_in(or_in),
      .clr(clr),
      .event_pulse(event_pulse),
      .level(level),
      .count(count),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and sample 1 time unit after it; tallies pulses seen.
   task automatic tick();
      @(posedge clk);
      #1;
      if (event_pulse === 1'b1) pulse_cnt++;
   endtask

   task automatic do_event();
      or_in = 1'b1;
      repeat (10) tick();
      or_in = 1'b0;
      repeat (10) tick();
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      or_in = 1'b1;
      clr   = 1'b0;
      #2;
      checks++;
      if (count !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: count=%0d overflow=%b expected 0/0", count, overflow);
      end
      repeat (8) tick();
      checks++;
      if (event_pulse !== 1'b0 || level !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: pulse=%b level=%b expected 0/0", event_pulse, level);
      end
      checks++;
      if (count !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_count: count=%0d overflow=%b expected 0/0", count, overflow);
      end
      or_in = 1'b0;
      tick();
      rst = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_single_event();
      pulse_cnt = 0;
      or_in = 1'b1;
      repeat (6) tick();
      checks++;
      if (event_pulse !== 1'b0 || level !== 1'b0 || count !== 4'd0) begin
         errors++;
         $display("FAIL latency_early: pulse=%b level=%b count=%0d expected 0/0/0", event_pulse, level, count);
      end
      tick();
      checks++;
      if (event_pulse !== 1'b1 || level !== 1'b1 || count !== 4'd1) begin
         errors++;
         $display("FAIL latency_edge: pulse=%b level=%b count=%0d expected 1/1/1", event_pulse, level, count);
      end
      tick();
      checks++;
      if (event_pulse !== 1'b0 || level !== 1'b1) begin
         errors++;
         $display("FAIL pulse_width: pulse=%b level=%b expected 0/1", event_pulse, level);
      end
      repeat (12) tick();
      checks++;
      if (pulse_cnt !== 1 || count !== 4'd1) begin
         errors++;
         $display("FAIL single_event: pulses=%0d count=%0d expected 1/1", pulse_cnt, count);
      end
      or_in = 1'b0;
      repeat (10) tick();
      checks++;
      if (level !== 1'b0 || pulse_cnt !== 1) begin
         errors++;
         $display("FAIL fall_release: level=%b pulses=%0d expected 0/1", level, pulse_cnt);
      end
   endtask

   task automatic test_glitch();
      do_clr();
      pulse_cnt = 0;
      or_in = 1'b1;
      repeat (3) tick();
      or_in = 1'b0;
      repeat (12) tick();
      checks++;
      if (pulse_cnt !== 0 || count !== 4'd0 || level !== 1'b0) begin
         errors++;
         $display("FAIL glitch_hi: pulses=%0d count=%0d level=%b expected 0/0/0", pulse_cnt, count, level);
      end
   endtask

   task automatic test_fall_glitch();
      pulse_cnt = 0;
      or_in = 1'b1;
      repeat (10) tick();
      or_in = 1'b0;
      repeat (2) tick();
      or_in = 1'b1;
      repeat (10) tick();
      checks++;
      if (level !== 1'b1 || pulse_cnt !== 1 || count !== 4'd1) begin
         errors++;
         $display("FAIL glitch_lo: level=%b pulses=%0d count=%0d expected 1/1/1", level, pulse_cnt, count);
      end
      or_in = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_overflow();
      do_clr();
      pulse_cnt = 0;
      repeat (15) do_event();
      checks++;
      if (count !== 4'd15 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL at_max: count=%0d overflow=%b expected 15/0", count, overflow);
      end
      do_event();
`ifdef OR_EVENT_CNT_SATURATE_EN
      checks++;
      if (count !== 4'd15 || overflow !== 1'b1 || pulse_cnt !== 16) begin
         errors++;
         $display("FAIL overflow_sat: count=%0d overflow=%b pulses=%0d expected 15/1/16", count, overflow, pulse_cnt);
      end
`else
      checks++;
      if (count !== 4'd0 || overflow !== 1'b1 || pulse_cnt !== 16) begin
         errors++;
         $display("FAIL overflow_wrap: count=%0d overflow=%b pulses=%0d expected 0/1/16", count, overflow, pulse_cnt);
      end
`endif
      do_event();
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: overflow=%b expected 1", overflow);
      end
      do_clr();
      checks++;
      if (count !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL clr: count=%0d overflow=%b expected 0/0", count, overflow);
      end
   endtask

   task automatic test_clr_with_event();
      repeat (5) do_event();
      checks++;
      if (count !== 4'd5) begin
         errors++;
         $display("FAIL five_events: count=%0d expected 5", count);
      end
      or_in = 1'b1;
      repeat (6) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (event_pulse !== 1'b1 || count !== 4'd0 || overflow !== 1'b0 || level !== 1'b1) begin
         errors++;
         $display("FAIL clr_vs_event: pulse=%b count=%0d overflow=%b level=%b expected 1/0/0/1",
                  event_pulse, count, overflow, level);
      end
      repeat (5) tick();
      or_in = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_rst_mid_debounce();
      do_event();
      or_in = 1'b1;
      repeat (4) tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (count !== 4'd0 || event_pulse !== 1'b0 || level !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: count=%0d pulse=%b level=%b overflow=%b expected all 0",
                  count, event_pulse, level, overflow);
      end
      tick();
      rst = 1'b0;
      pulse_cnt = 0;
      repeat (6) tick();
      checks++;
      if (event_pulse !== 1'b0 || count !== 4'd0) begin
         errors++;
         $display("FAIL rst_recount_early: pulse=%b count=%0d expected 0/0", event_pulse, count);
      end
      tick();
      checks++;
      if (event_pulse !== 1'b1 || count !== 4'd1 || level !== 1'b1) begin
         errors++;
         $display("FAIL rst_recount: pulse=%b count=%0d level=%b expected 1/1/1", event_pulse, count, level);
      end
      or_in = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      pulse_cnt = 0;
      test_reset();
      test_single_event();
      test_glitch();
      test_fall_glitch();
      test_overflow();
      test_clr_with_event();
      test_rst_mid_debounce();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
